// File: rtl/traffic_light_ctrl_if.sv
// Lamp-controller bus: tick/ped request in, lamp heads, countdown and phase pulse out.
interface traffic_light_ctrl_if;
    logic       tick;
    logic       ped_req;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [7:0] remaining;
    logic       phase_start;

    modport master (
        output tick, ped_req,
        input  ns_light, ew_light, remaining, phase_start
    );

    modport slave (
        input  tick, ped_req,
        output ns_light, ew_light, remaining, phase_start
    );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Tick-driven two-way intersection sequencer with per-phase countdown.
// Optional pedestrian green shortening is enabled by defining PED_REQ_EN.
module traffic_light_ctrl #(
    parameter int unsigned GREEN_TICKS     = 20,
    parameter int unsigned YELLOW_TICKS    = 3,
    parameter int unsigned ALLRED_TICKS    = 2,
    parameter int unsigned PED_GREEN_TICKS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    traffic_light_ctrl_if.slave  bus
);

    localparam int unsigned TW = 8;
    localparam logic [TW-1:0] G_LOAD  = TW'(GREEN_TICKS - 1);
    localparam logic [TW-1:0] Y_LOAD  = TW'(YELLOW_TICKS - 1);
    localparam logic [TW-1:0] AR_LOAD = TW'(ALLRED_TICKS - 1);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    typedef enum logic [2:0] {
        S_NSG, S_NSY, S_AR1, S_EWG, S_EWY, S_AR2
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    ns_q, ns_d;
    logic [2:0]    ew_q, ew_d;
    logic          ps_q, ps_d;

    // State register; reset parks in the second all-red so the first tick-run opens NS green.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_AR2;
            timer_q <= AR_LOAD;
            ns_q    <= LAMP_RED;
            ew_q    <= LAMP_RED;
            ps_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ns_q    <= ns_d;
            ew_q    <= ew_d;
            ps_q    <= ps_d;
        end
    end

`ifdef PED_REQ_EN
    localparam logic [TW-1:0] PED_LOAD = TW'(PED_GREEN_TICKS - 1);

    logic ped_q, ped_d;
    logic in_green, in_yellow_q, in_yellow_d;

    assign in_green    = (state_q == S_NSG) || (state_q == S_EWG);
    assign in_yellow_q = (state_q == S_NSY) || (state_q == S_EWY);
    assign in_yellow_d = (state_d == S_NSY) || (state_d == S_EWY);

    always_ff @(posedge clk) begin
        if (!reset) ped_q <= 1'b0;
        else        ped_q <= ped_d;
    end

    // A new request always wins over the yellow-entry clear so it is never lost.
    always_comb begin
        ped_d = ped_q;
        if (in_yellow_d && !in_yellow_q) ped_d = 1'b0;
        if (bus.ped_req)                 ped_d = 1'b1;
    end
`else
    logic ped_unused_c;
    assign ped_unused_c = bus.ped_req | (PED_GREEN_TICKS == 0);
`endif

    // Next-state and timer.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (bus.tick) begin
            if (timer_q == '0) begin
                unique case (state_q)
                    S_NSG:   state_d = S_NSY;
                    S_NSY:   state_d = S_AR1;
                    S_AR1:   state_d = S_EWG;
                    S_EWG:   state_d = S_EWY;
                    S_EWY:   state_d = S_AR2;
                    default: state_d = S_NSG;
                endcase
                unique case (state_d)
                    S_NSG, S_EWG: timer_d = G_LOAD;
                    S_NSY, S_EWY: timer_d = Y_LOAD;
                    default:      timer_d = AR_LOAD;
                endcase
            end else begin
                timer_d = timer_q - TW'(1);
            end
        end
`ifdef PED_REQ_EN
        if (ped_q && in_green && (timer_q > PED_LOAD)) timer_d = PED_LOAD;
`endif
    end

    // Lamp decode and phase pulse, taken from the next state so they register with it.
    always_comb begin
        ns_d = LAMP_RED;
        ew_d = LAMP_RED;
        ps_d = (state_d != state_q);
        unique case (state_d)
            S_NSG:   ns_d = LAMP_GREEN;
            S_NSY:   ns_d = LAMP_YELLOW;
            S_EWG:   ew_d = LAMP_GREEN;
            S_EWY:   ew_d = LAMP_YELLOW;
            default: begin
                ns_d = LAMP_RED;
                ew_d = LAMP_RED;
            end
        endcase
    end

    assign bus.ns_light    = ns_q;
    assign bus.ew_light    = ew_q;
    assign bus.remaining   = timer_q;
    assign bus.phase_start = ps_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench: stimulus queues expected phase entries, a monitor checks them on phase_start.
module tb_traffic_light_ctrl;

    typedef struct {
        logic [2:0] ns;
        logic [2:0] ew;
        logic [7:0] rem;
        int         cyc;
    } exp_t;

    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

    logic clk = 1'b0;
    logic reset_a, reset_b;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    traffic_light_ctrl_if bus_a();
    traffic_light_ctrl_if bus_b();

    traffic_light_ctrl #(.GREEN_TICKS(5), .YELLOW_TICKS(2), .ALLRED_TICKS(1),
                         .PED_GREEN_TICKS(1)) dut_a (
        .clk(clk), .reset(reset_a), .bus(bus_a.slave));

    traffic_light_ctrl #(.GREEN_TICKS(20), .YELLOW_TICKS(3), .ALLRED_TICKS(2),
                         .PED_GREEN_TICKS(5)) dut_b (
        .clk(clk), .reset(reset_b), .bus(bus_b.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // One tick on the selected DUT; gap=1 keeps tick high into the next call.
    task automatic pulse(input int sel, input int gap, input bit push, input exp_t e);
        @(negedge clk);
        if (sel == 0) bus_a.tick = 1'b1; else bus_b.tick = 1'b1;
        if (push) begin
            e.cyc = cyc + 1;
            if (sel == 0) q_a.push_back(e); else q_b.push_back(e);
        end
        if (gap > 1) begin
            @(negedge clk);
            if (sel == 0) bus_a.tick = 1'b0; else bus_b.tick = 1'b0;
            repeat (gap - 2) @(negedge clk);
        end
    endtask

    // n ticks; the last one must open the given phase.
    task automatic phase(input int sel, input int n, input int gap,
                         input logic [2:0] ns, input logic [2:0] ew, input logic [7:0] rem);
        exp_t e;
        e.ns = ns; e.ew = ew; e.rem = rem; e.cyc = 0;
        for (int i = 0; i < n; i++) pulse(sel, gap, (i == n - 1), e);
    endtask

    task automatic idle_ticks(input int sel, input int n, input int gap);
        exp_t e;
        e.ns = R; e.ew = R; e.rem = 8'd0; e.cyc = 0;
        for (int i = 0; i < n; i++) pulse(sel, gap, 1'b0, e);
    endtask

    task automatic ped_pulse();
        @(negedge clk);
        bus_b.tick    = 1'b0;
        bus_b.ped_req = 1'b1;
        @(negedge clk);
        bus_b.ped_req = 1'b0;
    endtask

    // Monitor: lamp safety every cycle, phase entries against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (cyc > 0) begin
            checks++;
            if (bus_a.ns_light != R && bus_a.ew_light != R) begin
                failures++;
                $display("FAIL heads_a: actual ns=%b ew=%b required one head red",
                         bus_a.ns_light, bus_a.ew_light);
            end
            checks++;
            if (bus_b.ns_light != R && bus_b.ew_light != R) begin
                failures++;
                $display("FAIL heads_b: actual ns=%b ew=%b required one head red",
                         bus_b.ns_light, bus_b.ew_light);
            end
            if (bus_a.phase_start === 1'b1) begin
                checks++;
                if (q_a.size() == 0) begin
                    failures++;
                    $display("FAIL phase_a: unexpected phase_start at cyc=%0d", cyc);
                end else begin
                    e = q_a.pop_front();
                    if (bus_a.ns_light != e.ns || bus_a.ew_light != e.ew ||
                        bus_a.remaining != e.rem || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL phase_a: actual ns=%b ew=%b rem=%0d cyc=%0d required ns=%b ew=%b rem=%0d cyc=%0d",
                                 bus_a.ns_light, bus_a.ew_light, bus_a.remaining, cyc,
                                 e.ns, e.ew, e.rem, e.cyc);
                    end
                end
            end
            if (bus_b.phase_start === 1'b1) begin
                checks++;
                if (q_b.size() == 0) begin
                    failures++;
                    $display("FAIL phase_b: unexpected phase_start at cyc=%0d", cyc);
                end else begin
                    e = q_b.pop_front();
                    if (bus_b.ns_light != e.ns || bus_b.ew_light != e.ew ||
                        bus_b.remaining != e.rem || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL phase_b: actual ns=%b ew=%b rem=%0d cyc=%0d required ns=%b ew=%b rem=%0d cyc=%0d",
                                 bus_b.ns_light, bus_b.ew_light, bus_b.remaining, cyc,
                                 e.ns, e.ew, e.rem, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        reset_a = 1'b0; reset_b = 1'b0;
        bus_a.tick = 1'b0; bus_a.ped_req = 1'b0;
        bus_b.tick = 1'b0; bus_b.ped_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_ns",  int'(bus_a.ns_light), int'(R));
        chk("rst_a_ew",  int'(bus_a.ew_light), int'(R));
        chk("rst_a_rem", int'(bus_a.remaining), 0);
        chk("rst_a_ps",  int'(bus_a.phase_start), 0);
        chk("rst_b_rem", int'(bus_b.remaining), 1);
        chk("rst_b_ps",  int'(bus_b.phase_start), 0);
        @(negedge clk);
        reset_a = 1'b1; reset_b = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_a_ps", int'(bus_a.phase_start), 0);

        // DUT A: G5 Y2 AR1, tick every 4 clocks; full cycle of 16 ticks.
        phase(0, 1, 4, G, R, 8'd4);
        phase(0, 5, 4, Y, R, 8'd1);
        phase(0, 2, 4, R, R, 8'd0);
        phase(0, 1, 4, R, G, 8'd4);
        phase(0, 5, 4, R, Y, 8'd1);
        phase(0, 2, 4, R, R, 8'd0);
        // Continuous tick from NS green entry: yellow appears exactly 5 clocks later.
        phase(0, 1, 1, G, R, 8'd4);
        phase(0, 5, 1, Y, R, 8'd1);
        phase(0, 2, 4, R, R, 8'd0);
        phase(0, 1, 4, R, G, 8'd4);
        idle_ticks(0, 2, 4);
        @(posedge clk); #1;
        chk("mid_ew_rem", int'(bus_a.remaining), 2);
        chk("mid_ew_lamp", int'(bus_a.ew_light), int'(G));
        // Reset together with tick abandons the phase.
        @(negedge clk);
        reset_a = 1'b0; bus_a.tick = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_ns",  int'(bus_a.ns_light), int'(R));
        chk("mid_rst_ew",  int'(bus_a.ew_light), int'(R));
        chk("mid_rst_rem", int'(bus_a.remaining), 0);
        chk("mid_rst_ps",  int'(bus_a.phase_start), 0);
        @(negedge clk);
        reset_a = 1'b1; bus_a.tick = 1'b0;

        // DUT B: G20 Y3 AR2 PED5, tick every 2 clocks.
        phase(1, 2, 2, G, R, 8'd19);
        idle_ticks(1, 4, 2);
        @(posedge clk); #1;
        chk("ped1_before", int'(bus_b.remaining), 15);
        ped_pulse();
        @(posedge clk); #1;
`ifdef PED_REQ_EN
        chk("ped1_cut", int'(bus_b.remaining), 4);
        phase(1, 5, 2, Y, R, 8'd2);
`else
        chk("ped1_cut", int'(bus_b.remaining), 15);
        phase(1, 16, 2, Y, R, 8'd2);
`endif
        phase(1, 3, 2, R, R, 8'd1);
        phase(1, 2, 2, R, G, 8'd19);
        phase(1, 20, 2, R, Y, 8'd2);
        phase(1, 3, 2, R, R, 8'd1);
        phase(1, 2, 2, G, R, 8'd19);
        phase(1, 20, 2, Y, R, 8'd2);
        phase(1, 3, 2, R, R, 8'd1);
        // Request during all-red shortens the following EW green.
        ped_pulse();
        phase(1, 2, 2, R, G, 8'd19);
        @(posedge clk); #1;
`ifdef PED_REQ_EN
        chk("ped_ar_cut", int'(bus_b.remaining), 4);
        phase(1, 5, 2, R, Y, 8'd2);
`else
        chk("ped_ar_cut", int'(bus_b.remaining), 19);
        phase(1, 20, 2, R, Y, 8'd2);
`endif
        phase(1, 3, 2, R, R, 8'd1);
        phase(1, 2, 2, G, R, 8'd19);
        // Request with remaining already below the cut has no timing effect.
        idle_ticks(1, 16, 2);
        @(posedge clk); #1;
        chk("ped_late_before", int'(bus_b.remaining), 3);
        ped_pulse();
        @(posedge clk); #1;
        chk("ped_late_after", int'(bus_b.remaining), 3);
        phase(1, 4, 2, Y, R, 8'd2);
        phase(1, 3, 2, R, R, 8'd1);
        phase(1, 2, 2, R, G, 8'd19);
        phase(1, 20, 2, R, Y, 8'd2);

        repeat (4) @(posedge clk);
        #1;
        chk("queue_a_drained", q_a.size(), 0);
        chk("queue_b_drained", q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Tick-driven two-way intersection controller: consumes the one-cycle `enable` strobe produced by the tick generator and sequences the north-south and east-west lamp heads through green, yellow and all-red phases. Each phase lasts a parameterised number of ticks. The block sits directly downstream of the tick generator and drives the lamp outputs plus a countdown value for the display.

## Interface
- `GREEN_TICKS`, default 20: green phase length in ticks (1..256).
- `YELLOW_TICKS`, default 3: yellow phase length in ticks (1..256).
- `ALLRED_TICKS`, default 2: all-red clearance length in ticks (1..256).
- `PED_GREEN_TICKS`, default 5: remaining green, in ticks, after a pedestrian request (1..GREEN_TICKS; used only with `PED_REQ_EN`).

- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-low reset.
- `tick`  in  1  one-cycle strobe from the tick generator; may be high on consecutive cycles.
- `ped_req`  in  1  pedestrian request pulse or level (`PED_REQ_EN` only; otherwise ignored).
- `ns_light`  out  3  north-south lamp, one-hot {red, yellow, green}.
- `ew_light`  out  3  east-west lamp, one-hot {red, yellow, green}.
- `remaining`  out  8  ticks left in the current phase minus one (the timer value).
- `phase_start`  out  1  one-cycle pulse on the first cycle of every new phase.

## Operation
- There are six states, visited in a fixed cycle: S_NSG → S_NSY → S_AR1 → S_EWG → S_EWY → S_AR2 → S_NSG.
- The 8-bit timer is loaded with the phase length minus one on entry to a state:
  - G states use GREEN_TICKS-1.
  - Y states use YELLOW_TICKS-1.
  - AR states use ALLRED_TICKS-1.
- On a cycle with `tick`=1:
  - timer>0: timer decrements.
  - timer==0: the state advances and the timer reloads for the new state.
- Cycles with `tick`=0 leave the state and timer unchanged.
- Lamp decode, all registered from the next-state value:
  - S_NSG: NS=001, EW=100.
  - S_NSY: NS=010, EW=100.
  - S_AR1 and S_AR2: NS=100, EW=100.
  - S_EWG: NS=100, EW=001.
  - S_EWY: NS=100, EW=010.
- The two heads are never green or yellow at the same time. No state decodes to both heads non-red.
- `remaining` equals the timer register at all times.

## Timing
- Reset (`reset`=0 sampled at a `clk` edge) forces:
  - state S_AR2 and timer ALLRED_TICKS-1.
  - `ns_light`=100, `ew_light`=100.
  - `remaining`=ALLRED_TICKS-1.
  - `phase_start`=0.
  - ped latch cleared.
- Reset overrides `tick` and `ped_req` in the same cycle. A reset asserted mid-phase abandons the phase immediately.
- After reset release, the first S_NSG is entered on the ALLRED_TICKS-th tick.
- State change, lamps and timer reload update on the same edge that samples `tick`=1 with timer==0. The latency from the tick to the lamp change is one clock.
- `phase_start` is high during the first cycle the new state is visible. It is 0 during the first cycle after reset.
- Back-to-back ticks are counted individually. A phase of N ticks with `tick` high continuously lasts exactly N clocks.
- A phase length of 1 loads timer 0, so the phase advances on its first tick.

## Configuration
- Macro: `PED_REQ_EN`.

Defined:
- `ped_req`=1 on any clock edge sets a pending latch.
- While in S_NSG or S_EWG with the latch set and timer > PED_GREEN_TICKS-1, the next edge loads timer PED_GREEN_TICKS-1. This load overrides a simultaneous tick decrement.
- The latch clears on entry to S_NSY or S_EWY.
- A request arriving during a Y or AR state stays pending and shortens the next green.
- A request arriving when the timer is already ≤ PED_GREEN_TICKS-1 has no timing effect. The latch still clears at the following yellow.

Undefined:
- `ped_req` is ignored and no latch is implemented.
- Green always lasts GREEN_TICKS.

## Test plan
Tests 1–4 use GREEN=5, YELLOW=2, ALLRED=1, with `tick` strobed every 4 clocks.

1. Reset release:
   - First tick → S_NSG, NS=001, EW=100, `remaining`=4, `phase_start`=1 for one clock.
2. Full cycle:
   - After reset, count ticks from S_NSG entry.
   - 5 ticks → S_NSY (`remaining`=1).
   - 2 more → S_AR1 (`remaining`=0).
   - 1 more → S_EWG.
   - After 16 ticks from S_NSG entry → back in S_NSG.
   - `ns_light` and `ew_light` are never both non-100.
3. Continuous `tick`=1 from S_NSG entry:
   - S_NSY is visible exactly 5 clocks later.
4. Reset mid-phase:
   - Assert `reset`=0 in S_EWG with `remaining`=2, together with `tick`=1.
   - Next edge shows S_AR2 state, NS=EW=100, `remaining`=0, `phase_start`=0.
5. `PED_REQ_EN` with GREEN=20, PED_GREEN=5:
   - `ped_req` pulse in S_NSG at `remaining`=15 → `remaining`=4 on the next edge.
   - S_NSY follows after 5 more ticks.
   - The next S_EWG lasts the full 20 ticks.
6. `PED_REQ_EN`, boundary cases:
   - `ped_req` during S_AR1 → the following S_EWG starts at `remaining`=19 and is cut to 4 on the next cycle.
   - `ped_req` with `remaining`=3 in green → no change.
   - Without the macro, the same stimulus → green is always 20 ticks.
